vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
- REQ-001: Parameter H_ACTIVE, default 480, visible pixels per line.
- REQ-002: Parameter H_FP, default 8, horizontal front porch in clocks.
- REQ-003: Parameter H_SYNC, default 4, hsync pulse width in clocks.
- REQ-004: Parameter H_BP, default 43, horizontal back porch in clocks.
- REQ-005: Parameter V_ACTIVE, default 272, visible lines per frame.
- REQ-006: Parameter V_FP, default 8, vertical front porch in lines.
- REQ-007: Parameter V_SYNC, default 4, vsync pulse width in lines.
- REQ-008: Parameter V_BP, default 12, vertical back porch in lines.
- REQ-009: Parameter SYNC_POL, default 0, asserted sync level (0 = active-low).
- REQ-010: One clock; reset is synchronous and active-high. Ports: i_clk input 1, pixel clock; i_rst input 1, synchronous active-high reset.
- REQ-011: o_x output 9, column of current visible pixel.
- REQ-012: o_y output 9, row of current visible pixel.
- REQ-013: o_de output 1, data enable, high in the visible area.
- REQ-014: o_hsync output 1, horizontal sync; o_vsync output 1, vertical sync.
- REQ-015: o_frame output 1, one-clock pulse per frame (frame tick for pattern sequencing).

Function
- REQ-016: Horizontal counter hc, 10 bits, SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 535), then wrap to 0.
- REQ-017: Vertical counter vc, 10 bits, SHALL increment only when hc wraps, count 0..V_TOTAL-1 (V_TOTAL = 296), then wrap to 0.
- REQ-018: Simultaneous hc and vc wrap SHALL yield (0,0) on the next clock; no skipped or duplicated line.
- REQ-019: Every output SHALL be registered and decoded from the current (hc,vc), giving exactly one clock latency, with all outputs mutually aligned.
- REQ-020: o_de SHALL be 1 iff hc < H_ACTIVE and vc < V_ACTIVE.
- REQ-021: o_x SHALL equal hc[8:0] and o_y SHALL equal vc[8:0] when o_de=1; both SHALL be 0 when o_de=0.
- REQ-022: o_hsync SHALL be at SYNC_POL iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (hc 488..491 at defaults); otherwise at ~SYNC_POL.
- REQ-023: o_vsync SHALL be at SYNC_POL iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (vc 280..283), for whole lines; otherwise at ~SYNC_POL.
- REQ-024: o_frame SHALL be high for exactly one clock, when hc=0 and vc=V_ACTIVE (first blanking line), i.e. once per H_TOTAL*V_TOTAL = 158360 clocks.
- REQ-025: H_ACTIVE and V_ACTIVE SHALL be <= 512; violating values SHALL fail elaboration.

Reset
- REQ-026: While i_rst=1: hc=0, vc=0, o_x=0, o_y=0, o_de=0, o_frame=0, o_hsync=o_vsync=~SYNC_POL.
- REQ-027: On the first clock after i_rst falls, outputs SHALL reflect (0,0): o_de=1, o_x=0, o_y=0.
- REQ-028: Reset asserted mid-frame SHALL abort the frame with no o_frame pulse, and the next frame SHALL start from (0,0).

Structure
- REQ-029: Shared package vga_pkg SHALL hold the default timing constants, H_TOTAL/V_TOTAL derivation and the 9-bit coordinate width.
- REQ-030: Sub-module vga_axis_counter (wrapping counter with enable, limit input and wrap output) SHALL be instantiated twice, for hc and vc.

Verification
- REQ-031: Reset 5 clocks, release -> outputs at REQ-026 values during reset; next clock o_de=1, o_x=0, o_y=0.
- REQ-032: Run one line -> o_de high 480 clocks, o_x 0..479 stepping by 1, o_hsync low for clocks 488..491, line period 535.
- REQ-033: Run two frames -> o_frame pulses exactly twice, 158360 clocks apart, at vc=272 with hc=0; o_vsync low for 4 lines from vc=280.
- REQ-034: Check the last pixel (hc=534, vc=295) -> the next output corresponds to (0,0) with o_de=1; no extra line.
- REQ-035: Assert i_rst at vc=100, hc=200 for 1 clock -> no o_frame pulse; restart at (0,0); the next o_frame pulse comes 272*535 clocks later.
- REQ-036: SYNC_POL=1 build -> sync pulses high at the same positions; idle level low.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, total-period derivation and the registered output bundle.
package vga_pkg;
  localparam int H_ACTIVE_D = 480;
  localparam int H_FP_D     = 8;
  localparam int H_SYNC_D   = 4;
  localparam int H_BP_D     = 43;
  localparam int V_ACTIVE_D = 272;
  localparam int V_FP_D     = 8;
  localparam int V_SYNC_D   = 4;
  localparam int V_BP_D     = 12;

  localparam int COORD_W    = 9;
  localparam int CNT_W      = 10;
  localparam int MAX_ACTIVE = 512;

  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_D = axis_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
  localparam int V_TOTAL_D = axis_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               de;
    logic               hsync;
    logic               vsync;
    logic               frame;
  } vga_out_t;
endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping counter 0..limit; wrap flags the enabled step that returns to zero.
module vga_axis_counter import vga_pkg::*; #(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);
  assign wrap = en && (count == limit);

  always_ff @(posedge i_clk) begin
    if (i_rst)   count <= '0;
    else if (en) count <= wrap ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: h/v position counters and a one-stage registered decode of all outputs.
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_de,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_frame
);
  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE > MAX_ACTIVE || V_ACTIVE > MAX_ACTIVE) begin : g_bad_active
    $error("vga_timing: active area exceeds 9-bit coordinate range");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
    $error("vga_timing: total period exceeds position counter range");
  end

  localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hc, vc;
  logic             h_wrap, unused_v_wrap;
  vga_out_t         nxt, out_q;

  vga_axis_counter #(.W(CNT_W)) u_hcnt (
    .i_clk (i_clk), .i_rst (i_rst), .en (1'b1), .limit (H_LIM),
    .count (hc), .wrap (h_wrap)
  );

  // vc steps only on the line wrap, so a double wrap lands on (0,0) in one clock.
  vga_axis_counter #(.W(CNT_W)) u_vcnt (
    .i_clk (i_clk), .i_rst (i_rst), .en (h_wrap), .limit (V_LIM),
    .count (vc), .wrap (unused_v_wrap)
  );

  always_comb begin
    nxt       = '0;
    nxt.de    = (hc < H_ACT) && (vc < V_ACT);
    if (nxt.de) begin
      nxt.x = hc[COORD_W-1:0];
      nxt.y = vc[COORD_W-1:0];
    end
    nxt.hsync = ((hc >= H_SS) && (hc < H_SE)) ? SYNC_POL : ~SYNC_POL;
    nxt.vsync = ((vc >= V_SS) && (vc < V_SE)) ? SYNC_POL : ~SYNC_POL;
    nxt.frame = (hc == '0) && (vc == V_ACT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) out_q <= '{x: '0, y: '0, de: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL, frame: 1'b0};
    else       out_q <= nxt;
  end

  assign o_x     = out_q.x;
  assign o_y     = out_q.y;
  assign o_de    = out_q.de;
  assign o_hsync = out_q.hsync;
  assign o_vsync = out_q.vsync;
  assign o_frame = out_q.frame;
endmodule
